// File: rtl/isa_pkg.sv
// Opcode map, encoded-word field positions and encoder types shared by the
// program-load encoder and the decode stage.
package isa_pkg;

  localparam logic [5:0] OP_LDI  = 6'h00;
  localparam logic [5:0] OP_MOV  = 6'h01;
  localparam logic [5:0] OP_LD   = 6'h02;
  localparam logic [5:0] OP_ST   = 6'h03;
  localparam logic [5:0] OP_ADD  = 6'h04;
  localparam logic [5:0] OP_SUB  = 6'h05;
  localparam logic [5:0] OP_AND  = 6'h06;
  localparam logic [5:0] OP_OR   = 6'h07;
  localparam logic [5:0] OP_XOR  = 6'h08;
  localparam logic [5:0] OP_NOR  = 6'h09;
  localparam logic [5:0] OP_SLT  = 6'h0A;
  localparam logic [5:0] OP_SLTU = 6'h0B;
  localparam logic [5:0] OP_MUL  = 6'h0C;
  localparam logic [5:0] OP_MULH = 6'h0D;
  localparam logic [5:0] OP_SLL  = 6'h0E;
  localparam logic [5:0] OP_SRA  = 6'h0F;
  localparam logic [5:0] OP_SHR  = 6'h10;
  localparam logic [5:0] OP_LAST_LEGAL = OP_SHR;

  // Low bit of each field inside the 32-bit word
  localparam int OP_LSB      = 26;
  localparam int RD2_LSB     = 21;
  localparam int RD1_LSB     = 16;
  localparam int RS2R_LSB    = 5;   // rs2 in R-type
  localparam int RS1_LSB     = 0;
  localparam int RS2_LSB     = 0;   // rs2 in MOV/ST
  localparam int MADDR_LSB   = 0;   // memory address in LD
  localparam int STADDR_LSB  = 18;  // memory address in ST
  localparam int IMM_LSB     = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } enc_state_t;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rd2;
    logic [4:0]  rd1;
    logic [4:0]  rs2;
    logic [4:0]  rs1;
    logic [15:0] imm;
    logic [7:0]  addr;
  } instr_fields_t;

  function automatic logic is_legal(input logic [5:0] op);
    return op <= OP_LAST_LEGAL;
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-bundle input stream plus IMEM write port of the instruction encoder.
// master = loader/IMEM side, slave = encoder.
interface instr_encoder_if #(
  parameter int AW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [5:0]    in_opcode;
  logic [4:0]    in_rd2;
  logic [4:0]    in_rd1;
  logic [4:0]    in_rs2;
  logic [4:0]    in_rs1;
  logic [15:0]   in_imm;
  logic [7:0]    in_addr;
  logic          imem_valid;
  logic          imem_ready;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;

  modport master (
    output in_valid, in_last, in_opcode, in_rd2, in_rd1, in_rs2, in_rs1,
           in_imm, in_addr, imem_ready,
    input  in_ready, imem_valid, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_last, in_opcode, in_rd2, in_rd1, in_rs2, in_rs1,
           in_imm, in_addr, imem_ready,
    output in_ready, imem_valid, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_pack.sv
// Combinational field packer: opcode + fields -> 32-bit instruction word.
// Unused bits stay 0; illegal opcodes produce a zero word and the flag.
module instr_pack
  import isa_pkg::*;
(
  input  instr_fields_t f,
  output logic [31:0]   word,
  output logic          illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    if (!is_legal(f.opcode)) begin
      illegal = 1'b1;
    end else begin
      word[OP_LSB +: 6] = f.opcode;
      if (f.opcode == OP_LDI) begin
        word[RD2_LSB +: 5] = f.rd2;
        word[IMM_LSB +: 16] = f.imm;
      end else if (f.opcode == OP_MOV) begin
        word[RD2_LSB +: 5] = f.rd2;
        word[RS2_LSB +: 5] = f.rs2;
      end else if (f.opcode == OP_LD) begin
        word[RD2_LSB +: 5]   = f.rd2;
        word[MADDR_LSB +: 8] = f.addr;
      end else if (f.opcode == OP_ST) begin
        word[STADDR_LSB +: 8] = f.addr;
        word[RS2_LSB +: 5]    = f.rs2;
      end else begin
        word[RD2_LSB +: 5]  = f.rd2;
        word[RD1_LSB +: 5]  = f.rd1;
        word[RS2R_LSB +: 5] = f.rs2;
        word[RS1_LSB +: 5]  = f.rs1;
      end
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Program-load path: accepts field bundles, packs them and streams the words
// into IMEM through a one-entry output register, with framing and errors.
module instr_encoder
  import isa_pkg::*;
#(
  parameter int AW    = 8,
  parameter int DEPTH = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [AW-1:0]   base_addr,
  instr_encoder_if.slave  bus,
  output logic            busy,
  output logic            done,
  output logic [AW:0]     words,
  output logic            err_illegal,
  output logic            err_full
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  enc_state_t    state_reg, state_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic [AW:0]   words_reg, words_next;
  logic          err_illegal_reg, err_illegal_next;
  logic          err_full_reg, err_full_next;
  logic          imem_valid_reg, imem_valid_next;
  logic [AW-1:0] imem_addr_reg, imem_addr_next;
  logic [31:0]   imem_wdata_reg, imem_wdata_next;

  instr_fields_t fields;
  logic [31:0]   packed_word;
  logic          packed_illegal;
  logic          in_ready_int;
  logic          accept;
  logic          full;

  assign fields = '{opcode: bus.in_opcode, rd2: bus.in_rd2, rd1: bus.in_rd1,
                    rs2: bus.in_rs2, rs1: bus.in_rs1, imm: bus.in_imm,
                    addr: bus.in_addr};

  instr_pack u_pack (
    .f       (fields),
    .word    (packed_word),
    .illegal (packed_illegal)
  );

  // A bundle may be taken whenever the output register is free or draining now
  assign in_ready_int = (state_reg == ST_RUN) && (!imem_valid_reg || bus.imem_ready);
  assign accept       = bus.in_valid && in_ready_int;
  assign full         = (words_reg == DEPTH_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      addr_reg        <= '0;
      words_reg       <= '0;
      err_illegal_reg <= 1'b0;
      err_full_reg    <= 1'b0;
      imem_valid_reg  <= 1'b0;
      imem_addr_reg   <= '0;
      imem_wdata_reg  <= '0;
    end else begin
      state_reg       <= state_next;
      addr_reg        <= addr_next;
      words_reg       <= words_next;
      err_illegal_reg <= err_illegal_next;
      err_full_reg    <= err_full_next;
      imem_valid_reg  <= imem_valid_next;
      imem_addr_reg   <= imem_addr_next;
      imem_wdata_reg  <= imem_wdata_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    addr_next        = addr_reg;
    words_next       = words_reg;
    err_illegal_next = err_illegal_reg;
    err_full_next    = err_full_reg;
    imem_valid_next  = imem_valid_reg && !bus.imem_ready;
    imem_addr_next   = imem_addr_reg;
    imem_wdata_next  = imem_wdata_reg;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next       = ST_RUN;
          addr_next        = base_addr;
          words_next       = '0;
          err_illegal_next = 1'b0;
          err_full_next    = 1'b0;
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (packed_illegal) begin
            err_illegal_next = 1'b1;
          end else if (full) begin
            err_full_next = 1'b1;
          end else begin
            // Reload overrides the drain above, so back-to-back has no bubble
            imem_valid_next = 1'b1;
            imem_addr_next  = addr_reg;
            imem_wdata_next = packed_word;
            addr_next       = addr_reg + AW'(1);
            words_next      = words_reg + (AW+1)'(1);
          end
          if (bus.in_last) begin
            state_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!imem_valid_reg) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.in_ready   = in_ready_int;
  assign bus.imem_valid = imem_valid_reg;
  assign bus.imem_addr  = imem_addr_reg;
  assign bus.imem_wdata = imem_wdata_reg;
  assign busy           = (state_reg != ST_IDLE);
  assign done           = (state_reg == ST_DONE);
  assign words          = words_reg;
  assign err_illegal    = err_illegal_reg;
  assign err_full       = err_full_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: table vectors, stall/abort sequences and a random
// program, all scored against a queue-based model of the IMEM writes.
module tb_instr_encoder;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rd2;
    logic [4:0]  rd1;
    logic [4:0]  rs2;
    logic [4:0]  rs1;
    logic [15:0] imm;
    logic [7:0]  ad;
    logic        last;
    logic [31:0] w;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Driver-side signals, steered to one of two DUTs by sel
  logic        sel = 1'b0;
  logic        drv_start = 1'b0;
  logic [7:0]  drv_base = '0;
  logic        drv_valid = 1'b0;
  logic        drv_last = 1'b0;
  logic [5:0]  drv_op = '0;
  logic [4:0]  drv_rd2 = '0, drv_rd1 = '0, drv_rs2 = '0, drv_rs1 = '0;
  logic [15:0] drv_imm = '0;
  logic [7:0]  drv_ad = '0;
  logic        imem_ready = 1'b1;
  logic        rdy_rand = 1'b0;

  instr_encoder_if #(.AW(8)) bi ();
  instr_encoder_if #(.AW(8)) bi4 ();

  logic       busy0, done0, eill0, efull0, busy4, done4, eill4, efull4;
  logic [8:0] words0, words4;

  assign bi.in_valid   = drv_valid & ~sel;
  assign bi4.in_valid  = drv_valid & sel;
  assign bi.in_last    = drv_last;   assign bi4.in_last   = drv_last;
  assign bi.in_opcode  = drv_op;     assign bi4.in_opcode = drv_op;
  assign bi.in_rd2     = drv_rd2;    assign bi4.in_rd2    = drv_rd2;
  assign bi.in_rd1     = drv_rd1;    assign bi4.in_rd1    = drv_rd1;
  assign bi.in_rs2     = drv_rs2;    assign bi4.in_rs2    = drv_rs2;
  assign bi.in_rs1     = drv_rs1;    assign bi4.in_rs1    = drv_rs1;
  assign bi.in_imm     = drv_imm;    assign bi4.in_imm    = drv_imm;
  assign bi.in_addr    = drv_ad;     assign bi4.in_addr   = drv_ad;
  assign bi.imem_ready = imem_ready; assign bi4.imem_ready = imem_ready;

  instr_encoder #(.AW(8), .DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n), .start(drv_start & ~sel), .base_addr(drv_base),
    .bus(bi.slave), .busy(busy0), .done(done0), .words(words0),
    .err_illegal(eill0), .err_full(efull0)
  );

  instr_encoder #(.AW(8), .DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(drv_start & sel), .base_addr(drv_base),
    .bus(bi4.slave), .busy(busy4), .done(done4), .words(words4),
    .err_illegal(eill4), .err_full(efull4)
  );

  logic        in_ready_m, vld_m, busy_m, done_m, eill_m, efull_m;
  logic [7:0]  addr_m;
  logic [31:0] wdata_m;
  logic [8:0]  words_m;
  assign in_ready_m = sel ? bi4.in_ready   : bi.in_ready;
  assign vld_m      = sel ? bi4.imem_valid : bi.imem_valid;
  assign addr_m     = sel ? bi4.imem_addr  : bi.imem_addr;
  assign wdata_m    = sel ? bi4.imem_wdata : bi.imem_wdata;
  assign busy_m     = sel ? busy4  : busy0;
  assign done_m     = sel ? done4  : done0;
  assign words_m    = sel ? words4 : words0;
  assign eill_m     = sel ? eill4  : eill0;
  assign efull_m    = sel ? efull4 : efull0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;

  // Reference model state
  wr_t         exp_q[$];
  logic [7:0]  wr_log[$];
  int unsigned m_addr = 0, m_words = 0, m_depth = 256;
  logic        m_ill = 1'b0, m_full = 1'b0, m_idle = 1'b1;
  wr_t         mon_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_encode(input int unsigned op, rd2, rd1, rs2, rs1, imm, ad);
    int unsigned w;
    if (op > 16) return 32'h0;
    w = op * (2**26);
    case (op)
      0:       w = w + rd2 * (2**21) + imm;
      1:       w = w + rd2 * (2**21) + rs2;
      2:       w = w + rd2 * (2**21) + ad;
      3:       w = w + ad * (2**18) + rs2;
      default: w = w + rd2 * (2**21) + rd1 * (2**16) + rs2 * 32 + rs1;
    endcase
    return w;
  endfunction

  // Write scoreboard: a write happens at the next edge whenever valid&ready
  always @(negedge clk) begin
    if (rst_n && vld_m && imem_ready) begin
      $display("wr addr=0x%02h data=0x%08h", addr_m, wdata_m);
      wr_log.push_back(addr_m);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h want none", addr_m, wdata_m);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(addr_m), 32'(mon_e.a));
        chk("wr_data", wdata_m, mon_e.d);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rdy_rand) imem_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic set_fields(input vec_t v);
    drv_op = v.op; drv_rd2 = v.rd2; drv_rd1 = v.rd1; drv_rs2 = v.rs2;
    drv_rs1 = v.rs1; drv_imm = v.imm; drv_ad = v.ad; drv_last = v.last;
    drv_valid = 1'b1;
  endtask

  task automatic do_start(input logic [7:0] base);
    drv_base = base;
    drv_start = 1'b1;
    if (m_idle) begin
      m_addr = base; m_words = 0; m_ill = 1'b0; m_full = 1'b0;
      m_depth = sel ? 4 : 256; m_idle = 1'b0;
    end
    tick();
    drv_start = 1'b0;
  endtask

  task automatic send(input vec_t v);
    bit ok = 0;
    int n = 0;
    wr_t e;
    set_fields(v);
    while (!ok && n < 200) begin
      @(negedge clk);
      if (in_ready_m) ok = 1;
      else begin tick(); n++; end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 for 200 cycles want 1");
    end else begin
      acc_cyc = cyc;
      $display("acc op=0x%02h last=%0d", v.op, v.last);
      if (v.ill) m_ill = 1'b1;
      else if (m_words == m_depth) m_full = 1'b1;
      else begin
        e.a = 8'(m_addr); e.d = v.w;
        exp_q.push_back(e);
        m_addr = (m_addr + 1) % 256;
        m_words++;
      end
    end
    tick();
    drv_valid = 1'b0;
    drv_last = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 0;
    int n = 0;
    while (!seen && n < 300) begin
      @(negedge clk);
      if (done_m) seen = 1;
      else begin tick(); n++; end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got done=0 for 300 cycles want 1");
    end else begin
      $display("done words=%0d err_illegal=%0d err_full=%0d", words_m, eill_m, efull_m);
      chk("done_words", 32'(words_m), m_words);
      chk("done_err_illegal", 32'(eill_m), 32'(m_ill));
      chk("done_err_full", 32'(efull_m), 32'(m_full));
      chk("done_queue_empty", exp_q.size(), 0);
      tick();
      @(negedge clk);
      chk("done_one_cycle", 32'(done_m), 0);
      chk("idle_after_done", 32'(busy_m), 0);
    end
    m_idle = 1'b1;
    tick();
  endtask

  vec_t tv[11];

  initial begin
    int c_first = 0;
    vec_t rv;

    tv[0]  = '{6'h04, 5'd3,  5'd4,  5'd5,  5'd6,  16'h0000, 8'h00, 1'b1, 32'h106400A6, 1'b0};
    tv[1]  = '{6'h00, 5'd1,  5'd0,  5'd0,  5'd0,  16'hBEEF, 8'h00, 1'b0, 32'h0020BEEF, 1'b0};
    tv[2]  = '{6'h03, 5'd0,  5'd0,  5'd7,  5'd0,  16'h0000, 8'hFF, 1'b0, 32'h0FFC0007, 1'b0};
    tv[3]  = '{6'h02, 5'd31, 5'd0,  5'd0,  5'd0,  16'h0000, 8'h12, 1'b1, 32'h0BE00012, 1'b0};
    tv[4]  = '{6'h01, 5'd2,  5'd0,  5'd9,  5'd0,  16'h0000, 8'h00, 1'b0, 32'h04400009, 1'b0};
    tv[5]  = '{6'h11, 5'd1,  5'd2,  5'd3,  5'd4,  16'hFFFF, 8'hAA, 1'b0, 32'h00000000, 1'b1};
    tv[6]  = '{6'h10, 5'd31, 5'd31, 5'd31, 5'd31, 16'h0000, 8'h00, 1'b1, 32'h43FF03FF, 1'b0};
    tv[7]  = '{6'h00, 5'd0,  5'd31, 5'd31, 5'd31, 16'h1234, 8'hFF, 1'b0, 32'h00001234, 1'b0};
    tv[8]  = '{6'h03, 5'd31, 5'd31, 5'd0,  5'd31, 16'hFFFF, 8'h01, 1'b0, 32'h0C040000, 1'b0};
    tv[9]  = '{6'h3F, 5'd7,  5'd7,  5'd7,  5'd7,  16'h7777, 8'h77, 1'b0, 32'h00000000, 1'b1};
    tv[10] = '{6'h05, 5'd0,  5'd1,  5'd2,  5'd3,  16'h0000, 8'h00, 1'b1, 32'h14010043, 1'b0};

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready_m), 0);
    chk("rst_imem_valid", 32'(vld_m), 0);
    chk("rst_imem_addr", 32'(addr_m), 0);
    chk("rst_imem_wdata", wdata_m, 0);
    chk("rst_busy", 32'(busy_m), 0);
    chk("rst_done", 32'(done_m), 0);
    chk("rst_words", 32'(words_m), 0);
    chk("rst_err_illegal", 32'(eill_m), 0);
    chk("rst_err_full", 32'(efull_m), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Table programs: A={0}, B={1..3}, C={4..6}, D={7..10}
    for (int i = 0; i < 11; i++) begin
      if (i == 0) do_start(8'h10);
      if (i == 1) do_start(8'h20);
      if (i == 4) do_start(8'h30);
      if (i == 7) do_start(8'h40);
      send(tv[i]);
      if (i == 0) begin
        @(negedge clk);
        chk("latency_addr", 32'(addr_m), 32'h10);
        chk("latency_data", wdata_m, 32'h106400A6);
      end
      if (i == 1) c_first = acc_cyc;
      if (i == 3) chk("b2b_cycles", 32'(acc_cyc - c_first), 2);
      if (i == 4) do_start(8'h80);
      if (i == 7) begin
        imem_ready = 1'b0;
        set_fields(tv[8]);
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("stall_in_ready", 32'(in_ready_m), 0);
          chk("stall_valid", 32'(vld_m), 1);
          chk("stall_addr", 32'(addr_m), (exp_q.size() > 0) ? 32'(exp_q[0].a) : 32'hFFFF);
          chk("stall_data", wdata_m, (exp_q.size() > 0) ? exp_q[0].d : 32'hFFFF);
          tick();
        end
        imem_ready = 1'b1;
      end
      if (tv[i].last) begin
        wait_done();
        if (i == 0) chk("prog_a_words", 32'(m_words), 1);
        if (i == 6) chk("prog_c_words", 32'(m_words), 2);
      end
    end

    // Depth limit with address wrap on the DEPTH=4 instance
    sel = 1'b1;
    tick();
    wr_log.delete();
    do_start(8'hFE);
    for (int i = 0; i < 6; i++) begin
      rv = '{6'h04, 5'(i), 5'(i + 1), 5'(i + 2), 5'(i + 3), 16'h0, 8'h0, (i == 5), 32'h0, 1'b0};
      rv.w = ref_encode(rv.op, rv.rd2, rv.rd1, rv.rs2, rv.rs1, rv.imm, rv.ad);
      send(rv);
    end
    wait_done();
    chk("full_nwrites", wr_log.size(), 4);
    if (wr_log.size() == 4) begin
      chk("full_addr0", 32'(wr_log[0]), 32'hFE);
      chk("full_addr1", 32'(wr_log[1]), 32'hFF);
      chk("full_addr2", 32'(wr_log[2]), 32'h00);
      chk("full_addr3", 32'(wr_log[3]), 32'h01);
    end
    chk("full_err", 32'(efull4), 1);
    chk("full_words", 32'(words4), 4);
    sel = 1'b0;
    tick();

    // Random program with random IMEM backpressure
    rdy_rand = 1'b1;
    do_start(8'($urandom_range(0, 255)));
    for (int i = 0; i < 150; i++) begin
      rv.op = 6'($urandom_range(0, 20));
      rv.rd2 = 5'($urandom); rv.rd1 = 5'($urandom); rv.rs2 = 5'($urandom);
      rv.rs1 = 5'($urandom); rv.imm = 16'($urandom); rv.ad = 8'($urandom);
      rv.last = (i == 149);
      rv.ill = (rv.op > 6'd16);
      rv.w = ref_encode(rv.op, rv.rd2, rv.rd1, rv.rs2, rv.rs1, rv.imm, rv.ad);
      send(rv);
    end
    wait_done();
    rdy_rand = 1'b0;
    imem_ready = 1'b1;

    // Reset while a write is pending aborts without a done pulse
    imem_ready = 1'b0;
    do_start(8'h50);
    send(tv[0]);
    do_start(8'h99);
    @(negedge clk);
    chk("abort_pending_valid", 32'(vld_m), 1);
    chk("abort_pending_addr", 32'(addr_m), 32'h50);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(vld_m), 0);
    chk("abort_busy", 32'(busy_m), 0);
    chk("abort_addr", 32'(addr_m), 0);
    chk("abort_data", wdata_m, 0);
    chk("abort_words", 32'(words_m), 0);
    chk("abort_in_ready", 32'(in_ready_m), 0);
    exp_q.delete();
    m_idle = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    imem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done_m), 0);
      tick();
    end

    // Recovery after abort
    do_start(8'h33);
    send(tv[6]);
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish by 1000000 want finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
